// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register plus architectural N/Z/V flags with stall/flush control.
// Optional macro FLAG_BYPASS_EN adds flag_nxt, the flags as they will be after the next edge.
module ex_flag_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [OP_W-1:0]   opcode,
    input  logic [DATA_W-1:0] result,
    input  logic              ovfl,
    input  logic [REG_W-1:0]  dst_reg,
    input  logic              wr_en,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_dst,
    output logic              out_wr_en,
`ifdef FLAG_BYPASS_EN
    output logic [2:0]        flag_nxt,
`endif
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_v
);

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] OP_SLL = OP_W'(4'b0100);
    localparam logic [OP_W-1:0] OP_SRA = OP_W'(4'b0101);
    localparam logic [OP_W-1:0] OP_ROR = OP_W'(4'b0110);

    logic              valid_q,  valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [REG_W-1:0]  dst_q,    dst_d;
    logic              wr_en_q,  wr_en_d;
    logic              n_q, n_d;
    logic              z_q, z_d;
    logic              v_q, v_d;

    logic upd_nzv;
    logic upd_z;

    always_comb begin
        upd_nzv = (opcode == OP_ADD) || (opcode == OP_SUB);
        upd_z   = upd_nzv || (opcode == OP_XOR) || (opcode == OP_SLL) ||
                  (opcode == OP_SRA) || (opcode == OP_ROR);
    end

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        dst_d    = dst_q;
        wr_en_d  = wr_en_q;
        n_d      = n_q;
        z_d      = z_q;
        v_d      = v_q;
        if (flush) begin
            // Bubble: payload is left as-is, only the qualifiers drop.
            valid_d = 1'b0;
            wr_en_d = 1'b0;
        end else if (!stall) begin
            valid_d  = in_valid;
            result_d = result;
            dst_d    = dst_reg;
            wr_en_d  = wr_en & in_valid;
            if (in_valid) begin
                if (upd_z) begin
                    z_d = (result == '0);
                end
                if (upd_nzv) begin
                    n_d = result[DATA_W-1];
                    v_d = ovfl;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            dst_q    <= '0;
            wr_en_q  <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            dst_q    <= dst_d;
            wr_en_q  <= wr_en_d;
            n_q      <= n_d;
            z_q      <= z_d;
            v_q      <= v_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_dst    = dst_q;
    assign out_wr_en  = wr_en_q;
    assign flag_n     = n_q;
    assign flag_z     = z_q;
    assign flag_v     = v_q;

`ifdef FLAG_BYPASS_EN
    // Reset has top priority at the edge, so the forwarded view must reflect it too.
    assign flag_nxt = rst_n ? {n_d, z_d, v_d} : 3'b000;
`endif

endmodule
